// File: rtl/seq_booth_mul.sv
// seq_booth_mul: iterative signed/unsigned multiplier, one multiplier bit per clock.
// Valid/ready handshakes on input and output; result is 2*WIDTH bits, exact product.
// Optional macro SEQ_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier
// bits are all zero (data-dependent latency 1..WIDTH cycles).
module seq_booth_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               smode_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] a_ext;
  logic               finish;

  // One iteration step: the multiplicand is kept pre-shifted by the iteration index
  // (mcand_q == Q << i) and the multiplier shifts right so the examined bit is always bit 0.
  always_comb begin
    a_ext   = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    acc_d   = acc_q;
    if (mplr_q[0]) begin
      // the two's-complement sign bit carries negative weight
      if (smode_q && (cnt_q == LAST_IDX)) acc_d = acc_q - mcand_q;
      else                                acc_d = acc_q + mcand_q;
    end
    mcand_d = mcand_q << 1;
    mplr_d  = mplr_q >> 1;
    cnt_d   = cnt_q + CNT_W'(1);
    finish  = (cnt_q == LAST_IDX);
`ifdef SEQ_MUL_EARLY_TERM_EN
    // bits above the current one are all zero: nothing left to add
    finish  = finish | (mplr_q[WIDTH-1:1] == '0);
`endif
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      smode_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= a_ext;
            mplr_q     <= b;
            smode_q    <= signed_mode;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_d;
          mplr_q  <= mplr_d;
          cnt_q   <= cnt_d;
          if (finish) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign result    = acc_q;

endmodule

// File: tb/tb_seq_booth_mul.sv
// tb_seq_booth_mul: self-checking bench for seq_booth_mul (WIDTH=32 and WIDTH=8 instances).
// Honours SEQ_MUL_EARLY_TERM_EN for expected latencies.
module tb_seq_booth_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv32, ir32, sm32, ov32, or32, bz32;
  logic [31:0] a32, b32;
  logic [63:0] r32;

  logic        iv8, ir8, sm8, ov8, or8, bz8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;

  int checks = 0;
  int errors = 0;

  seq_booth_mul #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .signed_mode(sm32), .out_valid(ov32), .out_ready(or32), .result(r32), .busy(bz32)
  );

  seq_booth_mul #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .result(r8), .busy(bz8)
  );

  // Exact product of two w-bit operands, interpreted per mode, reduced to 2*w bits.
  function automatic logic [127:0] ref_prod(input logic [63:0] x, input logic [63:0] y,
                                            input int w, input bit sm);
    logic [127:0] ex, ey, p, mask;
    ex = {64'b0, x} << (128 - w);
    ey = {64'b0, y} << (128 - w);
    if (sm) begin
      ex = $unsigned($signed(ex) >>> (128 - w));
      ey = $unsigned($signed(ey) >>> (128 - w));
    end else begin
      ex = ex >> (128 - w);
      ey = ey >> (128 - w);
    end
    p    = ex * ey;
    mask = (128'd1 << (2 * w)) - 128'd1;
    return p & mask;
  endfunction

  // Cycles from accept edge to out_valid.
  function automatic int exp_lat(input logic [63:0] y, input int w, input bit sm);
`ifdef SEQ_MUL_EARLY_TERM_EN
    if (sm && y[w-1]) return w;
    for (int k = w - 1; k >= 0; k--) if (y[k]) return k + 1;
    return 1;
`else
    return w;
`endif
  endfunction

  // Present one operation to the 32-bit instance and wait (bounded) for out_valid.
  task automatic op32(input logic [31:0] x, input logic [31:0] y, input bit sm, output int lat);
    iv32 = 1'b1; a32 = x; b32 = y; sm32 = sm;
    @(posedge clk); #1;
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    int stale;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", ir32); end
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov32); end
    checks++; if (r32 !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", r32); end
    checks++; if (bz32 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bz32); end
    checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin errors++; $display("FAIL reset_w8 got ir=%b ov=%b exp ir=1 ov=0", ir8, ov8); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // accept 5*7, then abort mid-operation
    iv32 = 1'b1; a32 = 32'd5; b32 = 32'd7; sm32 = 1'b0;
    @(posedge clk); #1;
    iv32 = 1'b0;
    @(posedge clk); #1;
    checks++; if (bz32 !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", bz32); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b exp=0", ov32); end
    checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b exp=1", ir32); end
    checks++; if (r32 !== 64'd0) begin errors++; $display("FAIL abort_result got=%h exp=0", r32); end
    checks++; if (bz32 !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bz32); end
    stale = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov32 !== 1'b0 || bz32 !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL abort_stale got=%0d exp=0", stale); end
    // reset coincident with in_valid: nothing accepted
    rst_n = 1'b0; iv32 = 1'b1; a32 = 32'd9; b32 = 32'd9;
    @(posedge clk); #1;
    iv32 = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bz32 !== 1'b0 || ir32 !== 1'b1) begin errors++; $display("FAIL reset_wins got busy=%b ir=%b exp busy=0 ir=1", bz32, ir32); end
  endtask

  task automatic test_signed_extremes();
    int lat;
    or32 = 1'b1;
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, lat);
    checks++; if (r32 !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL smin_sq_result got=%h exp=4000000000000000", r32); end
    checks++; if (lat != exp_lat(64'h8000_0000, 32, 1'b1)) begin errors++; $display("FAIL smin_sq_latency got=%0d exp=%0d", lat, exp_lat(64'h8000_0000, 32, 1'b1)); end
    @(posedge clk); #1;
    checks++; if (ov32 !== 1'b0 || ir32 !== 1'b1) begin errors++; $display("FAIL smin_sq_drain got ov=%b ir=%b exp ov=0 ir=1", ov32, ir32); end
    op32(32'hFFFF_FFFF, 32'd3, 1'b1, lat);
    checks++; if (r32 !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL neg1x3_result got=%h exp=fffffffffffffffd", r32); end
    checks++; if (lat != exp_lat(64'd3, 32, 1'b1)) begin errors++; $display("FAIL neg1x3_latency got=%0d exp=%0d", lat, exp_lat(64'd3, 32, 1'b1)); end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_max();
    int lat;
    or32 = 1'b1;
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    checks++; if (r32 !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL umax_result got=%h exp=fffffffe00000001", r32); end
    checks++; if (lat != exp_lat(64'hFFFF_FFFF, 32, 1'b0)) begin errors++; $display("FAIL umax_latency got=%0d exp=%0d", lat, exp_lat(64'hFFFF_FFFF, 32, 1'b0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    or32 = 1'b0;
    op32(32'd3, 32'd5, 1'b0, lat);
    checks++; if (r32 !== 64'd15) begin errors++; $display("FAIL bp_result got=%h exp=f", r32); end
    iv32 = 1'b1; a32 = 32'd1; b32 = 32'd1; sm32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ov32 !== 1'b1 || r32 !== 64'd15 || ir32 !== 1'b0 || bz32 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got ov=%b r=%h ir=%b busy=%b exp ov=1 r=f ir=0 busy=0", i, ov32, r32, ir32, bz32);
      end
    end
    or32 = 1'b1;
    @(posedge clk); #1;
    checks++; if (ov32 !== 1'b0 || ir32 !== 1'b1 || bz32 !== 1'b0) begin errors++; $display("FAIL bp_release got ov=%b ir=%b busy=%b exp ov=0 ir=1 busy=0", ov32, ir32, bz32); end
    @(posedge clk); #1;
    iv32 = 1'b0;
    checks++; if (bz32 !== 1'b1 || ir32 !== 1'b0) begin errors++; $display("FAIL bp_next_accept got busy=%b ir=%b exp busy=1 ir=0", bz32, ir32); end
    lat = 0;
    while (!ov32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (r32 !== 64'd1) begin errors++; $display("FAIL bp_next_result got=%h exp=1", r32); end
    checks++; if (lat != exp_lat(64'd1, 32, 1'b0)) begin errors++; $display("FAIL bp_next_latency got=%0d exp=%0d", lat, exp_lat(64'd1, 32, 1'b0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int lat;
    logic [63:0] exp_r [3];
    int exp_l [3];
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    bit tsm [3];
    ta[0] = 32'd9; tb[0] = 32'd0;          tsm[0] = 1'b0; exp_r[0] = 64'd0;
    ta[1] = 32'd9; tb[1] = 32'd2;          tsm[1] = 1'b0; exp_r[1] = 64'd18;
    ta[2] = 32'd9; tb[2] = 32'hFFFF_FFFF;  tsm[2] = 1'b1; exp_r[2] = 64'hFFFF_FFFF_FFFF_FFF7;
`ifdef SEQ_MUL_EARLY_TERM_EN
    exp_l[0] = 1; exp_l[1] = 2; exp_l[2] = 32;
`else
    exp_l[0] = 32; exp_l[1] = 32; exp_l[2] = 32;
`endif
    or32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op32(ta[i], tb[i], tsm[i], lat);
      checks++; if (r32 !== exp_r[i]) begin errors++; $display("FAIL lat_case%0d_result got=%h exp=%h", i, r32, exp_r[i]); end
      checks++; if (lat != exp_l[i]) begin errors++; $display("FAIL lat_case%0d_latency got=%0d exp=%0d", i, lat, exp_l[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sweep8();
    logic [7:0]  xa, xb;
    bit          xs, pre;
    logic [15:0] er;
    int          lat, el, guard;
    bit          drained;
    for (int n = 0; n < 2000; n++) begin
      xa = 8'($urandom); xb = 8'($urandom); xs = 1'($urandom);
      er = 16'(ref_prod({56'b0, xa}, {56'b0, xb}, 8, xs));
      el = exp_lat({56'b0, xb}, 8, xs);
      checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL sweep_ready op=%0d got=%b exp=1", n, ir8); end
      iv8 = 1'b1; a8 = xa; b8 = xb; sm8 = xs;
      @(posedge clk); #1;
      lat = 0;
      while (!ov8 && lat < 50) begin
        // garbage on the inputs while busy must be ignored
        iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        or8 = 1'($urandom);
        @(posedge clk); #1;
        lat++;
      end
      checks++; if (r8 !== er) begin errors++; $display("FAIL sweep_result op=%0d a=%h b=%h s=%0d got=%h exp=%h", n, xa, xb, xs, r8, er); end
      checks++; if (lat != el) begin errors++; $display("FAIL sweep_latency op=%0d got=%0d exp=%0d", n, lat, el); end
      drained = 1'b0;
      guard = 0;
      while (!drained && guard < 50) begin
        or8 = 1'($urandom);
        pre = or8;
        iv8 = 1'($urandom);
        @(posedge clk); #1;
        guard++;
        if (pre) begin
          drained = 1'b1;
          checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin errors++; $display("FAIL sweep_drain op=%0d got ov=%b ir=%b exp ov=0 ir=1", n, ov8, ir8); end
        end else begin
          checks++; if (ov8 !== 1'b1 || r8 !== er) begin errors++; $display("FAIL sweep_hold op=%0d got ov=%b r=%h exp ov=1 r=%h", n, ov8, r8, er); end
        end
      end
      iv8 = 1'b0;
      checks++; if (!drained) begin errors++; $display("FAIL sweep_drain_timeout op=%0d got=0 exp=1", n); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iv32 = 1'b0; a32 = '0; b32 = '0; sm32 = 1'b0; or32 = 1'b1;
    iv8 = 1'b0;  a8 = '0;  b8 = '0;  sm8 = 1'b0;  or8 = 1'b1;
    test_reset();
    test_signed_extremes();
    test_unsigned_max();
    test_back_to_back();
    test_latency();
    test_sweep8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
